// File: rtl/par_stream_fifo_if.sv
// Handshake bundle for par_stream_fifo: multi-word write side, multi-word read side, status flags.
// slave = FIFO side, master = producer/consumer side.
interface par_stream_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 16,
    parameter int PAR_WRITE  = 2,
    parameter int PAR_READ   = 2
);
    localparam int CW  = $clog2(SIZE + 1);
    localparam int WCW = $clog2(PAR_WRITE + 1);
    localparam int RCW = $clog2(PAR_READ + 1);

    logic                  wr_valid;
    logic [WCW-1:0]        wr_cnt;
    logic [DATA_WIDTH-1:0] wr_data [PAR_WRITE];
    logic                  wr_ready;

    logic                  rd_valid;
    logic [RCW-1:0]        rd_avail;
    logic [DATA_WIDTH-1:0] rd_data [PAR_READ];
    logic [RCW-1:0]        rd_cnt;
    logic                  rd_ready;

    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;

    modport slave (
        input  wr_valid, wr_cnt, wr_data, rd_cnt, rd_ready,
        output wr_ready, rd_valid, rd_avail, rd_data,
               count, full, empty, almost_full, almost_empty
    );

    modport master (
        output wr_valid, wr_cnt, wr_data, rd_cnt, rd_ready,
        input  wr_ready, rd_valid, rd_avail, rd_data,
               count, full, empty, almost_full, almost_empty
    );
endinterface

// File: rtl/par_stream_fifo.sv
// Multi-word elastic FIFO: up to PAR_WRITE words in and PAR_READ words out per cycle, any depth.
// Optional watermark flags enabled by defining PAR_FIFO_WATERMARK_EN.
module par_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 16,
    parameter int PAR_WRITE  = 2,
    parameter int PAR_READ   = 2,
    parameter int AF_LEVEL   = SIZE - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic             clk,
    input  logic             rst,
    par_stream_fifo_if.slave bus
);
    localparam int CW  = $clog2(SIZE + 1);
    localparam int WCW = $clog2(PAR_WRITE + 1);
    localparam int RCW = $clog2(PAR_READ + 1);
    localparam int PW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int PW1 = PW + 1;

    if (SIZE < PAR_WRITE || SIZE < PAR_READ || AF_LEVEL > SIZE || AE_LEVEL > SIZE) begin : g_bad_cfg
        $error("par_stream_fifo: SIZE must cover PAR_WRITE/PAR_READ and both watermark levels");
    end

    logic [DATA_WIDTH-1:0] mem [SIZE];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [PW-1:0]         wr_addr [PAR_WRITE];
    logic [PW-1:0]         rd_addr [PAR_READ];
    logic [WCW-1:0]        wr_amt;
    logic [RCW-1:0]        rd_amt;
    logic [RCW-1:0]        avail;
    logic                  wr_ready_i;
    logic                  rd_valid_i;
    logic                  wr_fire;

    // ptr < SIZE and inc <= SIZE, so one conditional subtract gives the modulo for any SIZE
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [PW1-1:0] inc);
        logic [PW1-1:0] sum;
        sum = {1'b0, ptr} + inc;
        if (sum >= PW1'(SIZE))
            sum = sum - PW1'(SIZE);
        return sum[PW-1:0];
    endfunction

    assign wr_ready_i = (count_q <= CW'(SIZE - PAR_WRITE));
    assign rd_valid_i = (count_q != '0);
    assign avail      = (count_q >= CW'(PAR_READ)) ? RCW'(PAR_READ) : RCW'(count_q);
    assign wr_fire    = bus.wr_valid && wr_ready_i && (bus.wr_cnt != '0);

    always_comb begin
        wr_amt = '0;
        if (wr_fire)
            wr_amt = (bus.wr_cnt > WCW'(PAR_WRITE)) ? WCW'(PAR_WRITE) : bus.wr_cnt;
    end

    always_comb begin
        rd_amt = '0;
        if (bus.rd_ready && rd_valid_i)
            rd_amt = (bus.rd_cnt > avail) ? avail : bus.rd_cnt;
    end

    always_comb begin
        for (int i = 0; i < PAR_WRITE; i++)
            wr_addr[i] = ptr_add(wr_ptr, PW1'(i));
    end

    always_comb begin
        for (int i = 0; i < PAR_READ; i++)
            rd_addr[i] = ptr_add(rd_ptr, PW1'(i));
    end

    // storage is intentionally left out of reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < PAR_WRITE; i++) begin
            if (WCW'(i) < wr_amt)
                mem[wr_addr[i]] <= bus.wr_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= ptr_add(wr_ptr, PW1'(wr_amt));
            rd_ptr  <= ptr_add(rd_ptr, PW1'(rd_amt));
            count_q <= count_q + CW'(wr_amt) - CW'(rd_amt);
        end
    end

    always_comb begin
        for (int i = 0; i < PAR_READ; i++)
            bus.rd_data[i] = mem[rd_addr[i]];
    end

    assign bus.wr_ready = wr_ready_i;
    assign bus.rd_valid = rd_valid_i;
    assign bus.rd_avail = avail;
    assign bus.count    = count_q;
    assign bus.full     = (count_q == CW'(SIZE));
    assign bus.empty    = (count_q == '0);

`ifdef PAR_FIFO_WATERMARK_EN
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
`else
    assign bus.almost_full  = 1'b0;
    assign bus.almost_empty = 1'b0;
`endif
endmodule

// File: tb/tb_par_stream_fifo.sv
// Self-checking bench for par_stream_fifo (SIZE=6, PAR_WRITE=2, PAR_READ=3) against a queue model.
module tb_par_stream_fifo;
    localparam int DW  = 8;
    localparam int SZ  = 6;
    localparam int PWR = 2;
    localparam int PRD = 3;
    localparam int AFL = 4;
    localparam int AEL = 1;
    localparam int CW  = $clog2(SZ + 1);
    localparam int RCW = $clog2(PRD + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [DW-1:0] model [$];

    par_stream_fifo_if #(.DATA_WIDTH(DW), .SIZE(SZ), .PAR_WRITE(PWR), .PAR_READ(PRD)) bus ();

    par_stream_fifo #(
        .DATA_WIDTH(DW), .SIZE(SZ), .PAR_WRITE(PWR), .PAR_READ(PRD),
        .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic exp_af(input int n);
`ifdef PAR_FIFO_WATERMARK_EN
        return n >= AFL;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_ae(input int n);
`ifdef PAR_FIFO_WATERMARK_EN
        return n <= AEL;
`else
        return 1'b0;
`endif
    endfunction

    task automatic idle_inputs();
        bus.wr_valid   = 1'b0;
        bus.wr_cnt     = '0;
        bus.wr_data[0] = '0;
        bus.wr_data[1] = '0;
        bus.rd_ready   = 1'b0;
        bus.rd_cnt     = '0;
    endtask

    // One clock edge; the model applies the FIFO rules to the pre-edge occupancy.
    task automatic cycle();
        int n, avail, wamt, ramt;
        logic [DW-1:0] nw [$];
        n     = model.size();
        avail = (n < PRD) ? n : PRD;
        wamt  = 0;
        ramt  = 0;
        if (bus.wr_valid && (SZ - n) >= PWR)
            wamt = (int'(bus.wr_cnt) > PWR) ? PWR : int'(bus.wr_cnt);
        if (bus.rd_ready && n > 0)
            ramt = (int'(bus.rd_cnt) < avail) ? int'(bus.rd_cnt) : avail;
        for (int i = 0; i < wamt; i++)
            nw.push_back(bus.wr_data[i]);
        @(posedge clk);
        repeat (ramt) void'(model.pop_front());
        foreach (nw[i]) model.push_back(nw[i]);
        #1;
    endtask

    task automatic put(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.wr_valid   = 1'b1;
        bus.wr_cnt     = 2'(k);
        bus.wr_data[0] = a;
        bus.wr_data[1] = b;
        cycle();
        bus.wr_valid = 1'b0;
        bus.wr_cnt   = '0;
    endtask

    task automatic pop(input int k);
        bus.rd_ready = 1'b1;
        bus.rd_cnt   = 2'(k);
        cycle();
        bus.rd_ready = 1'b0;
        bus.rd_cnt   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        model.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cycle();
        total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        total++; if (bus.rd_avail !== RCW'(0)) begin bad++; $display("FAIL reset_rd_avail: got %0d want 0", bus.rd_avail); end
        total++; if (bus.almost_empty !== exp_ae(0)) begin bad++; $display("FAIL reset_almost_empty: got %b want %b", bus.almost_empty, exp_ae(0)); end
        total++; if (bus.almost_full !== exp_af(0)) begin bad++; $display("FAIL reset_almost_full: got %b want %b", bus.almost_full, exp_af(0)); end
    endtask

    task automatic test_write_read();
        do_reset();
        put(2, 8'h11, 8'h22);
        put(2, 8'h33, 8'h44);
        total++; if (bus.count !== CW'(4)) begin bad++; $display("FAIL wr_count: got %0d want 4", bus.count); end
        total++; if (bus.almost_full !== exp_af(4)) begin bad++; $display("FAIL wr_almost_full: got %b want %b", bus.almost_full, exp_af(4)); end
        total++; if (bus.rd_avail !== RCW'(3)) begin bad++; $display("FAIL wr_rd_avail: got %0d want 3", bus.rd_avail); end
        total++; if (bus.rd_data[0] !== 8'h11) begin bad++; $display("FAIL wr_rd_data0: got %h want 11", bus.rd_data[0]); end
        total++; if (bus.rd_data[1] !== 8'h22) begin bad++; $display("FAIL wr_rd_data1: got %h want 22", bus.rd_data[1]); end
        total++; if (bus.rd_data[2] !== 8'h33) begin bad++; $display("FAIL wr_rd_data2: got %h want 33", bus.rd_data[2]); end
    endtask

    // Continues from test_write_read (count = 4).
    task automatic test_backpressure();
        put(1, 8'h55, 8'h00);
        total++; if (bus.count !== CW'(5)) begin bad++; $display("FAIL bp_count5: got %0d want 5", bus.count); end
        total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL bp_wr_ready_low: got %b want 0", bus.wr_ready); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL bp_full: got %b want 0", bus.full); end
        bus.wr_valid   = 1'b1;
        bus.wr_cnt     = 2'd2;
        bus.wr_data[0] = 8'h66;
        bus.wr_data[1] = 8'h77;
        cycle();
        cycle();
        bus.wr_valid = 1'b0;
        total++; if (bus.count !== CW'(5)) begin bad++; $display("FAIL bp_ignored: got %0d want 5", bus.count); end
        pop(3);
        total++; if (bus.count !== CW'(2)) begin bad++; $display("FAIL bp_pop_count: got %0d want 2", bus.count); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL bp_wr_ready_high: got %b want 1", bus.wr_ready); end
        total++; if (bus.rd_data[0] !== 8'h44) begin bad++; $display("FAIL bp_rd_data0: got %h want 44", bus.rd_data[0]); end
        total++; if (bus.rd_data[1] !== 8'h55) begin bad++; $display("FAIL bp_rd_data1: got %h want 55", bus.rd_data[1]); end
    endtask

    task automatic test_wrap();
        do_reset();
        put(2, 8'h01, 8'h02);
        put(2, 8'h03, 8'h04);
        put(1, 8'h05, 8'h00);
        pop(3);
        put(2, 8'hA0, 8'hA1);
        pop(1);
        total++; if (bus.count !== CW'(3)) begin bad++; $display("FAIL wrap_count: got %0d want 3", bus.count); end
        total++; if (bus.rd_data[0] !== 8'h05) begin bad++; $display("FAIL wrap_rd_data0: got %h want 05", bus.rd_data[0]); end
        total++; if (bus.rd_data[1] !== 8'hA0) begin bad++; $display("FAIL wrap_rd_data1: got %h want a0", bus.rd_data[1]); end
        total++; if (bus.rd_data[2] !== 8'hA1) begin bad++; $display("FAIL wrap_rd_data2: got %h want a1", bus.rd_data[2]); end
        pop(3);
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        put(2, 8'h01, 8'h02);
        put(1, 8'h03, 8'h00);
        bus.wr_valid   = 1'b1;
        bus.wr_cnt     = 2'd2;
        bus.wr_data[0] = 8'hB0;
        bus.wr_data[1] = 8'hB1;
        bus.rd_ready   = 1'b1;
        bus.rd_cnt     = 2'd3;
        cycle();
        idle_inputs();
        total++; if (bus.count !== CW'(2)) begin bad++; $display("FAIL sim_count: got %0d want 2", bus.count); end
        total++; if (bus.rd_data[0] !== 8'hB0) begin bad++; $display("FAIL sim_rd_data0: got %h want b0", bus.rd_data[0]); end
        total++; if (bus.rd_data[1] !== 8'hB1) begin bad++; $display("FAIL sim_rd_data1: got %h want b1", bus.rd_data[1]); end
    endtask

    task automatic test_over_read();
        do_reset();
        put(1, 8'hC0, 8'h00);
        pop(3);
        total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL over_count: got %0d want 0", bus.count); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL over_empty: got %b want 1", bus.empty); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL over_rd_valid: got %b want 0", bus.rd_valid); end
        put(2, 8'hC1, 8'hC2);
        total++; if (bus.rd_data[0] !== 8'hC1) begin bad++; $display("FAIL over_skew0: got %h want c1", bus.rd_data[0]); end
        total++; if (bus.rd_data[1] !== 8'hC2) begin bad++; $display("FAIL over_skew1: got %h want c2", bus.rd_data[1]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        put(2, 8'h01, 8'h02);
        put(2, 8'h03, 8'h04);
        put(1, 8'h05, 8'h00);
        total++; if (bus.count !== CW'(5)) begin bad++; $display("FAIL arst_pre_count: got %0d want 5", bus.count); end
        @(negedge clk);
        #2;
        rst = 1'b0;
        model.delete();
        #1;
        total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL arst_count: got %0d want 0", bus.count); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL arst_empty: got %b want 1", bus.empty); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL arst_wr_ready: got %b want 1", bus.wr_ready); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL arst_rd_valid: got %b want 0", bus.rd_valid); end
        total++; if (bus.almost_empty !== exp_ae(0)) begin bad++; $display("FAIL arst_almost_empty: got %b want %b", bus.almost_empty, exp_ae(0)); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        int n, avail, wp;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            wp = ((it / 50) % 2 == 0) ? 80 : 30;
            bus.wr_valid   = ($urandom_range(0, 99) < wp);
            bus.wr_cnt     = 2'($urandom_range(0, 3));
            bus.wr_data[0] = 8'($urandom);
            bus.wr_data[1] = 8'($urandom);
            bus.rd_ready   = ($urandom_range(0, 99) < (110 - wp));
            bus.rd_cnt     = 2'($urandom_range(0, 3));
            cycle();
            n     = model.size();
            avail = (n < PRD) ? n : PRD;
            total++; if (bus.count !== CW'(n)) begin bad++; $display("FAIL rnd_count it=%0d: got %0d want %0d", it, bus.count, n); end
            total++; if (bus.empty !== (n == 0)) begin bad++; $display("FAIL rnd_empty it=%0d: got %b want %b", it, bus.empty, n == 0); end
            total++; if (bus.full !== (n == SZ)) begin bad++; $display("FAIL rnd_full it=%0d: got %b want %b", it, bus.full, n == SZ); end
            total++; if (bus.wr_ready !== ((SZ - n) >= PWR)) begin bad++; $display("FAIL rnd_wr_ready it=%0d: got %b want %b", it, bus.wr_ready, (SZ - n) >= PWR); end
            total++; if (bus.rd_valid !== (n > 0)) begin bad++; $display("FAIL rnd_rd_valid it=%0d: got %b want %b", it, bus.rd_valid, n > 0); end
            total++; if (bus.rd_avail !== RCW'(avail)) begin bad++; $display("FAIL rnd_rd_avail it=%0d: got %0d want %0d", it, bus.rd_avail, avail); end
            total++; if (bus.almost_full !== exp_af(n)) begin bad++; $display("FAIL rnd_almost_full it=%0d: got %b want %b", it, bus.almost_full, exp_af(n)); end
            total++; if (bus.almost_empty !== exp_ae(n)) begin bad++; $display("FAIL rnd_almost_empty it=%0d: got %b want %b", it, bus.almost_empty, exp_ae(n)); end
            for (int i = 0; i < avail; i++) begin
                total++;
                if (bus.rd_data[i] !== model[i]) begin
                    bad++;
                    $display("FAIL rnd_rd_data it=%0d idx=%0d: got %h want %h", it, i, bus.rd_data[i], model[i]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_backpressure();
        test_wrap();
        test_simultaneous();
        test_over_read();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
